uart_rx: RTL and testbench

Serial UART receiver for the simple-uart design: it recovers 8N1 frames from the asynchronous `rx` pin and presents each byte as a parallel word with a one-cycle valid strobe. It sits under the UART top level, beside the transmitter. The top level drives `rx_en` from its BTN3 on/off toggle and drives the LD6 colours from `rx_en`, `rx_valid` and `rx_frame_err`. Bit timing is derived by counting `sysclk` cycles; no oversampling clock is used.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling by counting
// sysclk cycles, registered parallel byte with one-cycle valid / frame-error strobes.
module uart_rx #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS:0]   shift_w;

  // Synchroniser idles at 1 so reset never looks like a start bit.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s    = sync_q[1];
  assign shift_w = {rx_s, sh_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_en && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          // Right shift: first bit on the wire lands in the LSB.
          sh_d  = shift_w[DATA_BITS:1];
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Disable aborts any frame in flight without a strobe.
    if (state_q != S_IDLE && !rx_en) begin
      state_d = S_IDLE;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = busy_q;
  assign rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frame-level reference model predicts each
// strobe's cycle, kind and data; observed strobes are logged and compared.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;  // edge E to strobe, 154

  logic       sysclk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .rx_en       (rx_en),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .rx_frame_err(rx_frame_err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int       cyc;
    bit       err;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  ev_t        exq[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         both_cnt = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Log every strobe with the cycle index of the edge that raised it.
  always @(negedge sysclk) begin
    if (!rst) begin
      if (rx_valid && rx_frame_err) both_cnt++;
      if (rx_valid)     evq.push_back('{cyc: cyc, err: 1'b0, d: rx_data});
      if (rx_frame_err) evq.push_back('{cyc: cyc, err: 1'b1, d: rx_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one frame starting at edge e yields one strobe LAT later.
  task automatic expect_frame(input int e, input logic [7:0] b, input bit stop_ok);
    ev_t x;
    x.cyc = e + LAT;
    x.err = !stop_ok;
    if (stop_ok) begin
      x.d       = b;
      last_good = b;
    end else begin
      x.d = last_good;
    end
    exq.push_back(x);
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, "_count"}, evq.size(), exq.size());
    for (int i = 0; i < exq.size() && i < evq.size(); i++) begin
      chk({tag, "_cyc"},  evq[i].cyc, exq[i].cyc);
      chk({tag, "_kind"}, {31'd0, evq[i].err}, {31'd0, exq[i].err});
      chk({tag, "_data"}, {24'd0, evq[i].d}, {24'd0, exq[i].d});
    end
    evq.delete();
    exq.delete();
  endtask

  // Called at a negedge; returns the index of the edge sampling the start bit.
  task automatic send_frame(input logic [7:0] b, input bit stop, output int e);
    rx = 1'b0;
    e  = cyc + 1;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    rx = stop;
    repeat (CPB) @(negedge sysclk);
    rx = 1'b1;
  endtask

  initial begin
    int         e, e2;
    logic [7:0] b;
    bit         ok;

    rst   = 1'b1;
    rx    = 1'b1;
    rx_en = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("rst_data",  {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_busy",  {31'd0, rx_busy}, 32'h0);
    chk("rst_err",   {31'd0, rx_frame_err}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge sysclk);

    // Good frame
    send_frame(8'hA5, 1'b1, e);
    expect_frame(e, 8'hA5, 1'b1);
    repeat (5) @(negedge sysclk);
    chk("good_busy_idle", {31'd0, rx_busy}, 32'h0);
    cmp_events("good");

    // Glitch start: 4 low cycles
    rx = 1'b0;
    e  = cyc + 1;
    repeat (4) @(negedge sysclk);
    rx = 1'b1;
    while (cyc < e + 5) @(negedge sysclk);
    chk("glitch_busy_seen", {31'd0, rx_busy}, 32'h1);
    while (cyc < e + 12) @(negedge sysclk);
    chk("glitch_busy_idle", {31'd0, rx_busy}, 32'h0);
    repeat (20) @(negedge sysclk);
    cmp_events("glitch");

    // Bad stop bit, line held low, then recovery
    send_frame(8'h3C, 1'b0, e);
    expect_frame(e, 8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge sysclk);
    chk("brk_data_kept", {24'd0, rx_data}, 32'hA5);
    rx = 1'b1;
    repeat (20) @(negedge sysclk);
    send_frame(8'h5A, 1'b1, e);
    expect_frame(e, 8'h5A, 1'b1);
    repeat (5) @(negedge sysclk);
    cmp_events("badstop");

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, e);
    expect_frame(e, 8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, e2);
    expect_frame(e2, 8'hFF, 1'b1);
    repeat (5) @(negedge sysclk);
    if (evq.size() >= 2) chk("b2b_spacing", evq[1].cyc - evq[0].cyc, 32'd160);
    cmp_events("b2b");

    // Disable during data bit 3
    fork
      send_frame(8'($urandom), 1'b1, e);
      begin
        repeat (4 * CPB + 8) @(negedge sysclk);
        chk("dis_busy_before", {31'd0, rx_busy}, 32'h1);
        rx_en = 1'b0;
        @(negedge sysclk);
        chk("dis_busy_after", {31'd0, rx_busy}, 32'h0);
      end
    join
    repeat (5) @(negedge sysclk);
    rx_en = 1'b1;
    repeat (5) @(negedge sysclk);
    cmp_events("dis_none");
    send_frame(8'h81, 1'b1, e);
    expect_frame(e, 8'h81, 1'b1);
    repeat (5) @(negedge sysclk);
    cmp_events("dis_recover");

    // Asynchronous reset during data bit 5, held until the line is idle
    fork
      send_frame(8'h33, 1'b1, e);
      begin
        repeat (6 * CPB + 8) @(negedge sysclk);
        chk("mrst_busy_before", {31'd0, rx_busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_data",  {24'd0, rx_data}, 32'h0);
        chk("mrst_valid", {31'd0, rx_valid}, 32'h0);
        chk("mrst_busy",  {31'd0, rx_busy}, 32'h0);
        chk("mrst_err",   {31'd0, rx_frame_err}, 32'h0);
        last_good = 8'h00;
      end
    join
    rst = 1'b0;
    repeat (5) @(negedge sysclk);
    cmp_events("mrst_none");
    send_frame(8'h7E, 1'b1, e);
    expect_frame(e, 8'h7E, 1'b1);
    repeat (5) @(negedge sysclk);
    cmp_events("mrst_recover");

    // Random frames, occasional bad stop bits, random idle gaps
    for (int k = 0; k < 24; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, e);
      expect_frame(e, b, ok);
      repeat (ok ? $urandom_range(0, 5) : $urandom_range(3, 8)) @(negedge sysclk);
    end
    repeat (10) @(negedge sysclk);
    cmp_events("rand");
    chk("never_both", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
